// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned shift-and-add multiplier that drives an external
// combinational WIDTH-bit adder and rebuilds the adder's lost carry-out.
module shift_add_mult_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     m_reg;
  logic [2*WIDTH-1:0]   p;
  logic [CNT_W-1:0]     count;
  logic                 carry;
  logic [2*WIDTH-1:0]   p_next;

  // The adder has no carry-out; a wrapped sum is smaller than add_a exactly
  // when the true sum overflowed, since add_b never exceeds 2^WIDTH-1.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    add_a  = p[2*WIDTH-1:WIDTH];
    add_b  = (state == RUN && p[0]) ? m_reg : '0;
    carry  = (add_sum < add_a);
    p_next = {carry, add_sum, p[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: all registers (operands included) are reset so an abandoned
  // multiply leaves no stale data visible on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m_reg   <= '0;
      p       <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            p     <= {{WIDTH{1'b0}}, multiplier};
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p     <= p_next;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            product <= p_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Scoreboard bench for shift_add_mult_seq with a behavioural adder,
// randomized traffic and directed corner cases.
module tb_shift_add_mult_seq;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_sum;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: edge index, last accepted edge, scoreboard queue.
  int             cyc        = 0;
  int             acc_edge   = 0;
  bit             acc_valid  = 0;
  int             next_free  = 0;
  logic [W-1:0]   cur_m      = '0;
  logic [2*W-1:0] model_prod = '0;
  int             n_done     = 0;
  exp_t           sb[$];

  shift_add_mult_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Behavioural model of the team's WIDTH-bit adder (wraps, no carry out).
  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Expected number of overflowing additions for M*Q, from partial sums.
  function automatic int exp_carries(input logic [W-1:0] m, input logic [W-1:0] q);
    longint unsigned hi;
    int n = 0;
    for (int i = 0; i < W; i++) begin
      if (q[i]) begin
        hi = (longint'(m) * (longint'(q) & ((64'd1 << i) - 1))) >> i;
        if (hi + longint'(m) >= (64'd1 << W)) n++;
      end
    end
    return n;
  endfunction

  // Stimulus-side model: a start seen while the multiplier is free is accepted
  // and its product is due WIDTH edges later; it is free again WIDTH+2 edges on.
  always @(posedge clk) begin
    cyc++;
    if (!rst && start && cyc >= next_free) begin
      sb.push_back('{prod: (2*W)'(multiplicand) * (2*W)'(multiplier), due: cyc + W});
      acc_edge  = cyc;
      acc_valid = 1;
      next_free = cyc + W + 2;
      cur_m     = multiplicand;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    bit   exp_busy;
    bit   exp_done;
    exp_t e;
    exp_busy = acc_valid && cyc >= acc_edge && cyc < acc_edge + W;
    exp_done = acc_valid && cyc == acc_edge + W;
    check("busy", 64'(busy), 64'(exp_busy));
    check("done", 64'(done), 64'(exp_done));
    if (done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("product", 64'(product), 64'(e.prod));
        check("done_cycle", 64'(cyc), 64'(e.due));
        model_prod = e.prod;
        n_done++;
      end
    end
    check("product_hold", 64'(product), 64'(model_prod));
    if (!exp_busy) check("add_b_idle", 64'(add_b), 64'd0);
    else if (add_b != '0) check("add_b_value", 64'(add_b), 64'(cur_m));
  end

  // mode 0: plain; mode 1: count carries; mode 2: add_b must stay zero.
  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] q, input int mode);
    int carries = 0;
    @(posedge clk); #1;
    start = 1'b1; multiplicand = m; multiplier = q;
    @(posedge clk); #1;
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      if (mode == 1 && busy && add_sum < add_a) carries++;
      if (mode == 2) check("add_b_zero", 64'(add_b), 64'd0);
    end
    if (mode == 1) check("carry_count", 64'(carries), 64'(exp_carries(m, q)));
    @(posedge clk);
  endtask

  initial begin
    int done_before;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    @(negedge clk) rst = 1'b0;

    run_mul(16'd1209, 16'd1000, 0);
    check("p1209x1000", 64'(product), 64'h0012_72A8);
    run_mul(16'hFFFF, 16'hFFFF, 1);
    check("pFFFFxFFFF", 64'(product), 64'hFFFE_0001);
    run_mul(16'd0, 16'hABCD, 0);
    check("p0xABCD", 64'(product), 64'd0);
    run_mul(16'h1234, 16'd0, 2);
    check("p1234x0", 64'(product), 64'd0);

    // start held over two full slots with operands changing every cycle
    done_before = n_done;
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      multiplicand = $urandom; multiplier = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    check("held_start_count", 64'(n_done - done_before), 64'd2);

    // asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    start = 1'b1; multiplicand = 16'd3; multiplier = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    sb.delete(); acc_valid = 0; next_free = 0; model_prod = '0;
    @(negedge clk) rst = 1'b0;
    run_mul(16'd3, 16'd5, 0);
    check("p3x5", 64'(product), 64'd15);

    // back-to-back: the monitor checks 63 holds through the second run
    run_mul(16'd7, 16'd9, 0);
    check("p7x9", 64'(product), 64'd63);
    run_mul(16'd100, 16'd200, 0);
    check("p100x200", 64'(product), 64'd20000);

    // random traffic, including starts while busy and corner operands
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       multiplicand = 16'hFFFF;
        1:       multiplicand = '0;
        default: multiplicand = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       multiplier = 16'hFFFF;
        1:       multiplier = 16'd1;
        default: multiplier = $urandom;
      endcase
    end
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: bench did not finish within 20000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
